// File: rtl/mpc_channel_kob.sv
// Keep-order buffer for one memory channel: hands out slot IDs in order, collects
// bank responses out of order, and releases them strictly in allocation order.
module mpc_channel_kob #(
    parameter int         KOB_SIZE   = 8,
    parameter logic [1:0] CHANNEL_ID = 2'd0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         alloc_valid_i,
    output logic         alloc_ready_o,
    output logic [2:0]   alloc_rob_id_o,
    input  logic         rc_valid_i,
    input  logic [132:0] rc_rsp_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [127:0] rsp_o,
    output logic [3:0]   count_o,
    output logic         err_o
);

    localparam int IDX_W = $clog2(KOB_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [KOB_SIZE-1:0] pending_q;
    logic [KOB_SIZE-1:0] done_q;
    logic [127:0]        rdata_q [KOB_SIZE];
    logic [IDX_W-1:0]    head_q;
    logic [IDX_W-1:0]    tail_q;
    logic [CNT_W-1:0]    count_q;
    logic                err_q;

    logic [1:0]       rc_channel;
    logic [IDX_W-1:0] rc_id;
    logic [127:0]     rc_data;
    logic             rc_accept;
    logic             rc_error;
    logic             alloc_fire;
    logic             retire_fire;

    // rc_rsp_i layout: {channel_id[1:0], rob_id[2:0], rdata[127:0]}
    assign rc_channel = rc_rsp_i[132:131];
    assign rc_id      = rc_rsp_i[128 +: IDX_W];
    assign rc_data    = rc_rsp_i[127:0];

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; ready never depends on the partner's valid, and a raised rsp_valid_o with
    // its rsp_o holds until taken.
    assign alloc_ready_o  = (count_q < CNT_W'(KOB_SIZE));
    assign alloc_rob_id_o = 3'(tail_q);
    assign alloc_fire     = alloc_valid_i && alloc_ready_o;

    assign rsp_valid_o = pending_q[head_q] && done_q[head_q];
    assign rsp_o       = rdata_q[head_q];
    assign retire_fire = rsp_valid_o && rsp_ready_i;

    // Only an outstanding, not-yet-completed slot of this channel may be written.
    assign rc_accept = rc_valid_i && (rc_channel == CHANNEL_ID)
                       && pending_q[rc_id] && !done_q[rc_id];
    assign rc_error  = rc_valid_i && !rc_accept;

    assign count_o = 4'(count_q);
    assign err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= '0;
            done_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (alloc_fire) begin
                pending_q[tail_q] <= 1'b1;
                done_q[tail_q]    <= 1'b0;
                tail_q            <= tail_q + 1'b1;
            end
            if (rc_accept) begin
                done_q[rc_id] <= 1'b1;
            end
            // The retiring head is done, so it can never be the slot allocated or
            // completed in this same cycle.
            if (retire_fire) begin
                pending_q[head_q] <= 1'b0;
                done_q[head_q]    <= 1'b0;
                head_q            <= head_q + 1'b1;
            end
            case ({alloc_fire, retire_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (rc_error) begin
                err_q <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; validity lives in pending_q/done_q.
    always_ff @(posedge clk_i) begin
        if (rc_accept) begin
            rdata_q[rc_id] <= rc_data;
        end
    end

endmodule

// File: tb/tb_mpc_channel_kob.sv
// Self-checking bench for mpc_channel_kob: vector table plus hand-written sequences,
// with a scoreboard queue checking retired data against allocation order.
module tb_mpc_channel_kob;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         alloc_valid_i = 1'b0;
    logic         alloc_ready_o;
    logic [2:0]   alloc_rob_id_o;
    logic         rc_valid_i = 1'b0;
    logic [132:0] rc_rsp_i = '0;
    logic         rsp_valid_o;
    logic         rsp_ready_i = 1'b0;
    logic [127:0] rsp_o;
    logic [3:0]   count_o;
    logic         err_o;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];
    logic [2:0]   m_tail = '0;

    mpc_channel_kob #(.KOB_SIZE(8), .CHANNEL_ID(2'd0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_rob_id_o(alloc_rob_id_o),
        .rc_valid_i(rc_valid_i), .rc_rsp_i(rc_rsp_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_o(rsp_o),
        .count_o(count_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         alloc_v;
        logic [127:0] alloc_data;
        logic         rc_v;
        logic [1:0]   rc_ch;
        logic [2:0]   rc_id;
        logic [127:0] rc_data;
        logic         rsp_rdy;
        logic         e_ready;
        logic [2:0]   e_rob_id;
        logic         e_valid;
        logic [127:0] e_rsp;
        logic [3:0]   e_count;
        logic         e_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: every retire handshake pops the oldest allocated payload.
    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_rsp actual=%0h required=none", rsp_o);
            end else begin
                check("sb_rsp_data", rsp_o, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        alloc_valid_i = 1'b0;
        rc_valid_i    = 1'b0;
        rsp_ready_i   = 1'b0;
        rst_ni        = 1'b0;
        tick();
        check("rst_alloc_ready", 128'(alloc_ready_o), 128'(1));
        check("rst_rob_id", 128'(alloc_rob_id_o), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
        check("rst_count", 128'(count_o), 128'(0));
        check("rst_err", 128'(err_o), 128'(0));
        exp_q.delete();
        m_tail = '0;
        rst_ni = 1'b1;
    endtask

    task automatic do_alloc(input logic [127:0] data);
        check("alloc_ready", 128'(alloc_ready_o), 128'(1));
        check("alloc_rob_id", 128'(alloc_rob_id_o), 128'(m_tail));
        alloc_valid_i = 1'b1;
        exp_q.push_back(data);
        tick();
        alloc_valid_i = 1'b0;
        m_tail = m_tail + 3'd1;
    endtask

    task automatic do_rc(input logic [1:0] ch, input logic [2:0] id, input logic [127:0] data);
        rc_valid_i = 1'b1;
        rc_rsp_i   = {ch, id, data};
        tick();
        rc_valid_i = 1'b0;
    endtask

    initial begin
        //            alloc data      rc ch    id    rc data      rdy  rdy  rob   val  rsp      cnt   err
        vecs[0]  = '{1'b1, 128'hA, 1'b0, 2'd0, 3'd0, 128'h0,  1'b0, 1'b1, 3'd1, 1'b0, 128'h0, 4'd1, 1'b0};
        vecs[1]  = '{1'b1, 128'hB, 1'b0, 2'd0, 3'd0, 128'h0,  1'b0, 1'b1, 3'd2, 1'b0, 128'h0, 4'd2, 1'b0};
        vecs[2]  = '{1'b1, 128'hC, 1'b0, 2'd0, 3'd0, 128'h0,  1'b0, 1'b1, 3'd3, 1'b0, 128'h0, 4'd3, 1'b0};
        vecs[3]  = '{1'b0, 128'h0, 1'b1, 2'd0, 3'd0, 128'hA, 1'b1, 1'b1, 3'd3, 1'b1, 128'hA, 4'd3, 1'b0};
        vecs[4]  = '{1'b0, 128'h0, 1'b1, 2'd0, 3'd1, 128'hB, 1'b1, 1'b1, 3'd3, 1'b1, 128'hB, 4'd2, 1'b0};
        vecs[5]  = '{1'b0, 128'h0, 1'b1, 2'd0, 3'd2, 128'hC, 1'b1, 1'b1, 3'd3, 1'b1, 128'hC, 4'd1, 1'b0};
        vecs[6]  = '{1'b0, 128'h0, 1'b0, 2'd0, 3'd0, 128'h0, 1'b1, 1'b1, 3'd3, 1'b0, 128'h0, 4'd0, 1'b0};
        vecs[7]  = '{1'b1, 128'hD, 1'b0, 2'd0, 3'd0, 128'h0,  1'b0, 1'b1, 3'd4, 1'b0, 128'h0, 4'd1, 1'b0};
        vecs[8]  = '{1'b0, 128'h0, 1'b1, 2'd1, 3'd3, 128'h55, 1'b0, 1'b1, 3'd4, 1'b0, 128'h0, 4'd1, 1'b1};
        vecs[9]  = '{1'b0, 128'h0, 1'b1, 2'd0, 3'd3, 128'hD, 1'b0, 1'b1, 3'd4, 1'b1, 128'hD, 4'd1, 1'b1};
        vecs[10] = '{1'b0, 128'h0, 1'b1, 2'd0, 3'd3, 128'hEE, 1'b0, 1'b1, 3'd4, 1'b1, 128'hD, 4'd1, 1'b1};
        vecs[11] = '{1'b0, 128'h0, 1'b0, 2'd0, 3'd0, 128'h0, 1'b1, 1'b1, 3'd4, 1'b0, 128'h0, 4'd0, 1'b1};

        do_reset();

        // In-order flow, wrong-channel and duplicate responses
        for (int i = 0; i < 12; i++) begin
            alloc_valid_i = vecs[i].alloc_v;
            if (vecs[i].alloc_v) exp_q.push_back(vecs[i].alloc_data);
            rc_valid_i  = vecs[i].rc_v;
            rc_rsp_i    = {vecs[i].rc_ch, vecs[i].rc_id, vecs[i].rc_data};
            rsp_ready_i = vecs[i].rsp_rdy;
            tick();
            check($sformatf("v%0d_alloc_ready", i), 128'(alloc_ready_o), 128'(vecs[i].e_ready));
            check($sformatf("v%0d_rob_id", i), 128'(alloc_rob_id_o), 128'(vecs[i].e_rob_id));
            check($sformatf("v%0d_rsp_valid", i), 128'(rsp_valid_o), 128'(vecs[i].e_valid));
            if (vecs[i].e_valid) check($sformatf("v%0d_rsp", i), rsp_o, vecs[i].e_rsp);
            check($sformatf("v%0d_count", i), 128'(count_o), 128'(vecs[i].e_count));
            check($sformatf("v%0d_err", i), 128'(err_o), 128'(vecs[i].e_err));
        end
        alloc_valid_i = 1'b0;
        rc_valid_i    = 1'b0;
        rsp_ready_i   = 1'b0;
        check("table_sb_empty", 128'(exp_q.size()), 128'(0));

        // Out-of-order completion: 3,1,2,0
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(128'h10 + 128'(i));
        rsp_ready_i = 1'b1;
        do_rc(2'd0, 3'd3, 128'h13);
        check("ooo_hold3", 128'(rsp_valid_o), 128'(0));
        do_rc(2'd0, 3'd1, 128'h11);
        check("ooo_hold1", 128'(rsp_valid_o), 128'(0));
        do_rc(2'd0, 3'd2, 128'h12);
        check("ooo_hold2", 128'(rsp_valid_o), 128'(0));
        do_rc(2'd0, 3'd0, 128'h10);
        check("ooo_release", 128'(rsp_valid_o), 128'(1));
        for (int i = 0; i < 4; i++) tick();
        check("ooo_count", 128'(count_o), 128'(0));
        check("ooo_valid_end", 128'(rsp_valid_o), 128'(0));
        check("ooo_sb_empty", 128'(exp_q.size()), 128'(0));
        rsp_ready_i = 1'b0;

        // Full, then retire with alloc pending: allocation lands a cycle later at slot 0
        do_reset();
        for (int i = 0; i < 8; i++) do_alloc(128'h20 + 128'(i));
        check("full_ready", 128'(alloc_ready_o), 128'(0));
        check("full_count", 128'(count_o), 128'(8));
        do_rc(2'd0, 3'd0, 128'h20);
        alloc_valid_i = 1'b1;
        rsp_ready_i   = 1'b1;
        check("full_no_bypass", 128'(alloc_ready_o), 128'(0));
        tick();
        check("wrap_count7", 128'(count_o), 128'(7));
        check("wrap_ready", 128'(alloc_ready_o), 128'(1));
        check("wrap_rob_id", 128'(alloc_rob_id_o), 128'(0));
        exp_q.push_back(128'h28);
        rsp_ready_i = 1'b0;
        tick();
        alloc_valid_i = 1'b0;
        check("wrap_count8", 128'(count_o), 128'(8));
        rsp_ready_i = 1'b1;
        for (int i = 1; i < 8; i++) do_rc(2'd0, 3'(i), 128'h20 + 128'(i));
        do_rc(2'd0, 3'd0, 128'h28);
        for (int i = 0; i < 20 && count_o != 4'd0; i++) tick();
        check("drain_count", 128'(count_o), 128'(0));
        check("drain_sb_empty", 128'(exp_q.size()), 128'(0));
        check("drain_err", 128'(err_o), 128'(0));
        rsp_ready_i = 1'b0;

        // Backpressure: head done but not taken for 5 cycles
        do_reset();
        do_alloc(128'h77);
        do_rc(2'd0, 3'd0, 128'h77);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid_%0d", i), 128'(rsp_valid_o), 128'(1));
            check($sformatf("bp_data_%0d", i), rsp_o, 128'h77);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check("bp_count", 128'(count_o), 128'(0));
        check("bp_valid_end", 128'(rsp_valid_o), 128'(0));

        // Response to an unallocated slot
        do_reset();
        do_rc(2'd0, 3'd2, 128'h5);
        check("unalloc_err", 128'(err_o), 128'(1));
        check("unalloc_count", 128'(count_o), 128'(0));
        check("unalloc_valid", 128'(rsp_valid_o), 128'(0));

        // Response to the slot being allocated in the same cycle
        do_reset();
        alloc_valid_i = 1'b1;
        exp_q.push_back(128'h31);
        do_rc(2'd0, 3'd0, 128'h31);
        alloc_valid_i = 1'b0;
        check("same_cyc_err", 128'(err_o), 128'(1));
        check("same_cyc_count", 128'(count_o), 128'(1));
        check("same_cyc_valid", 128'(rsp_valid_o), 128'(0));

        // Duplicate response keeps the first payload
        do_reset();
        do_alloc(128'h30);
        do_rc(2'd0, 3'd0, 128'h30);
        check("dup_err_before", 128'(err_o), 128'(0));
        do_rc(2'd0, 3'd0, 128'h99);
        check("dup_err", 128'(err_o), 128'(1));
        check("dup_count", 128'(count_o), 128'(1));
        check("dup_data", rsp_o, 128'h30);

        // Reset mid-run: 3 pending, 1 done
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(128'h40 + 128'(i));
        do_rc(2'd0, 3'd1, 128'h41);
        check("mid_count", 128'(count_o), 128'(4));
        do_reset();
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("post_rst_valid_%0d", i), 128'(rsp_valid_o), 128'(0));
        end
        check("post_rst_count", 128'(count_o), 128'(0));
        rsp_ready_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mpc_channel_kob.md
MPC_CHANNEL_KOB -- requirements
Module: mpc_channel_kob

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter KOB_SIZE, default 8: number of keep-order entries; a power of two, at least 2.
REQ-002 The block SHALL have parameter CHANNEL_ID, default 2'd0: the channel this instance serves.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk_i, input, 1: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1: synchronous, active-low reset.
REQ-005 The block SHALL have port alloc_valid_i, input, 1: the channel is issuing a request (mpc_types::channel_req_t) to the banks and needs an order slot.
REQ-006 The block SHALL have port alloc_ready_o, output, 1: a slot is free.
REQ-007 The block SHALL have port alloc_rob_id_o, output, 3: the slot ID granted; it is carried in bank_req_t and returned in rc_rsp_t.rob_id.
REQ-008 The block SHALL have port rc_valid_i, input, 1: a bank response is present.
REQ-009 The block SHALL have port rc_rsp_i, input, 133: mpc_types::rc_rsp_t {channel_id, rob_id, rdata}.
REQ-010 The block SHALL have port rsp_valid_o, output, 1: an in-order response is available.
REQ-011 The block SHALL have port rsp_ready_i, input, 1: the channel accepts the response.
REQ-012 The block SHALL have port rsp_o, output, 128: mpc_types::channel_rsp_t {rdata}.
REQ-013 The block SHALL have port count_o, output, 4: the number of occupied slots, 0..KOB_SIZE.
REQ-014 The block SHALL have port err_o, output, 1: a sticky protocol-error flag.

Function
REQ-015 Storage SHALL be KOB_SIZE entries, each holding {pending, done, rdata[127:0]}, plus a head pointer, a tail pointer (each log2(KOB_SIZE) bits, wrapping modulo KOB_SIZE) and a count (log2(KOB_SIZE)+1 bits).
REQ-016 alloc_ready_o SHALL be (count < KOB_SIZE) and SHALL depend only on registered state, never on rsp_ready_i, so there is no full-bypass.
REQ-017 alloc_rob_id_o SHALL equal tail whenever alloc_ready_o is high.
REQ-018 On an alloc handshake (alloc_valid_i & alloc_ready_o), at the next edge the block SHALL set entry[tail].pending=1, set done=0 and advance tail by 1, wrapping from KOB_SIZE-1 to 0.
REQ-019 On rc_valid_i, a response SHALL be accepted only when rc_rsp_i.channel_id == CHANNEL_ID and entry[rob_id] is pending with done=0; at the next edge the block SHALL write rdata and set done=1.
REQ-020 There SHALL be no rc_ready output: responses are always accepted, and at most one rc response is processed per cycle.
REQ-021 An rc response that fails REQ-019 (wrong channel, slot not pending, or slot already done) SHALL be dropped without any state change and SHALL set err_o=1 at the next edge; err_o stays high until reset.
REQ-022 rsp_valid_o SHALL equal entry[head].pending & entry[head].done; rsp_o SHALL equal entry[head].rdata, driven combinationally from registers.
REQ-023 The minimum latency from the rc_valid_i edge to rsp_valid_o is 1 cycle; there SHALL be no combinational path from rc_* to rsp_*.
REQ-024 Once rsp_valid_o is high, rsp_valid_o and rsp_o SHALL hold stable until rsp_ready_i is sampled high.
REQ-025 On a retire handshake (rsp_valid_o & rsp_ready_i), at the next edge the block SHALL clear entry[head].pending and entry[head].done and advance head by 1, wrapping.
REQ-026 count SHALL update as follows:
- alloc handshake only: +1
- retire only: -1
- alloc and retire in the same cycle: unchanged
REQ-027 count_o SHALL equal count.
REQ-028 Responses completing out of order SHALL be held until every older slot has retired, so retirement order equals allocation order.
REQ-029 An rc response that targets the slot being allocated in the same cycle is not pending and SHALL be treated as an error under REQ-021.
REQ-030 An rc response to entry[head] in the same cycle as a retire is impossible, because the head must already be done to retire; if the response still arrives, it SHALL be flagged as an error under REQ-021 ("already done").
REQ-031 When count == 0, rsp_valid_o SHALL be 0.
REQ-032 When count == KOB_SIZE, head == tail and alloc_ready_o SHALL be 0.

Reset
REQ-033 While rst_ni is sampled low at a rising edge, the block SHALL clear all of the following, at that edge:
- head, tail and count to 0
- every pending and done bit to 0
- err_o to 0
REQ-034 The rdata storage need not be reset.
REQ-035 During and immediately after reset, the outputs SHALL be: alloc_ready_o=1, alloc_rob_id_o=0, rsp_valid_o=0, count_o=0, err_o=0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight entries without emitting any response.

Verification
REQ-037 In order: allocate IDs 0,1,2; return rc for 0,1,2 with rdata 0xA,0xB,0xC; hold rsp_ready_i=1 -> rsp_o = 0xA,0xB,0xC on consecutive cycles; count_o ends at 0.
REQ-038 Out of order: allocate 0..3; return rc in order 3,1,2,0 -> rsp_valid_o stays 0 until slot 0 completes, then 4 responses appear in order 0,1,2,3.
REQ-039 Full and wrap:
- allocate 8 -> alloc_ready_o=0 and count_o=8
- complete slot 0, retire it while alloc_valid_i=1 -> allocation occurs only on the following cycle, with alloc_rob_id_o=0 (wrap)
REQ-040 Backpressure: head done, rsp_ready_i=0 for 5 cycles -> rsp_valid_o=1 and rsp_o stable throughout; retire on the 6th cycle.
REQ-041 Errors, each leaving count_o unchanged and no response emitted:
- rc with channel_id != CHANNEL_ID -> err_o=1
- rc to an unallocated slot -> err_o=1
- duplicate rc to the same slot -> err_o=1
REQ-042 Reset mid-run: 3 pending, 1 done; drive rst_ni=0 for one cycle -> all outputs at their reset values and no rsp_valid_o afterwards.
